ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 206 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Iterative RV32M multiply/divide unit that sits in the EX stage.
//               A 32-step shift-add multiplier and a 32-step restoring divider
//               share one 64-bit working register. The pipeline is held via
//               stall_o while an operation is running. Divide-by-zero and
//               signed overflow bypass the iteration and finish in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  op_i,
  input  logic [6:0]  funct7_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o
);

  localparam logic [6:0]  C_OP_REG     = 7'b0110011;
  localparam logic [6:0]  C_F7_MULDIV  = 7'b0000001;
  localparam logic [4:0]  C_LAST_ITER  = 5'd31;
  localparam logic [31:0] C_INT_MIN    = 32'h80000000;
  localparam logic [31:0] C_ALL_ONES   = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  // Multiply: {running high half, remaining multiplier bits}.
  // Divide  : {partial remainder, dividend bits shifting into quotient}.
  logic [63:0] r_acc;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [31:0] r_opnd;
  // Negate the product (multiply) or the quotient (divide).
  logic        r_neg_lo;
  // Negate the remainder (dividend was negative).
  logic        r_neg_rem;

  // ---------------------------------------------------------------------------
  // Request decode and operand conditioning (valid only while accepting)
  // ---------------------------------------------------------------------------
  logic        w_req;
  logic        w_a_sgn;
  logic        w_b_sgn;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_fast;
  logic [31:0] w_fast_res;

  assign w_req = (op_i == C_OP_REG) && (funct7_i == C_F7_MULDIV);

  // Divides are signed unless funct3[0] is set. For multiplies only MULHU
  // treats rs1 as unsigned, and only MULHSU/MULHU treat rs2 as unsigned.
  // MUL returns the low half, which is the same for any signedness.
  assign w_a_sgn = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
  assign w_b_sgn = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];

  assign w_a_mag = (w_a_sgn && rs1_data_i[31]) ? -rs1_data_i : rs1_data_i;
  assign w_b_mag = (w_b_sgn && rs2_data_i[31]) ? -rs2_data_i : rs2_data_i;

  assign w_div_zero = (rs2_data_i == 32'd0);
  assign w_div_ovf  = ~funct3_i[0] && (rs1_data_i == C_INT_MIN) &&
                      (rs2_data_i == C_ALL_ONES);
  assign w_fast     = funct3_i[2] && (w_div_zero || w_div_ovf);

  // funct3[1] selects remainder (REM/REMU) versus quotient (DIV/DIVU).
  always_comb begin
    w_fast_res = 32'd0;
    if (w_div_zero) begin
      w_fast_res = funct3_i[1] ? rs1_data_i : C_ALL_ONES;
    end else begin
      w_fast_res = funct3_i[1] ? 32'd0 : C_INT_MIN;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply step: add multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole product right by one.
  // ---------------------------------------------------------------------------
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  logic [63:0] w_prod;
  logic [31:0] w_mul_res;

  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_nxt = {w_mul_sum, r_acc[31:1]};
  assign w_prod    = r_neg_lo ? -w_mul_nxt : w_mul_nxt;
  assign w_mul_res = (r_f3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

  // ---------------------------------------------------------------------------
  // Divide step: shift the next dividend bit into the remainder and subtract
  // the divisor when it fits. The trial remainder is always below the divisor
  // after a step, so 32 bits are enough to hold it.
  // ---------------------------------------------------------------------------
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem_sub;
  logic [63:0] w_div_nxt;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_div_res;

  assign w_shift   = {r_acc[63:32], r_acc[31]};
  assign w_ge      = (w_shift >= {1'b0, r_opnd});
  assign w_rem_sub = w_shift[31:0] - r_opnd;
  assign w_div_nxt = w_ge ? {w_rem_sub,     r_acc[30:0], 1'b1}
                          : {w_shift[31:0], r_acc[30:0], 1'b0};
  assign w_quo     = w_div_nxt[31:0];
  assign w_rem     = w_div_nxt[63:32];
  assign w_div_res = r_f3[1] ? (r_neg_rem ? -w_rem : w_rem)
                             : (r_neg_lo  ? -w_quo : w_quo);

  // ---------------------------------------------------------------------------
  // Control FSM with datapath registers; flush overrides every state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_f3      <= 3'd0;
      r_rd      <= 5'd0;
      r_acc     <= 64'd0;
      r_opnd    <= 32'd0;
      r_neg_lo  <= 1'b0;
      r_neg_rem <= 1'b0;
      result_o  <= 32'd0;
      rd_o      <= 5'd0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_f3      <= funct3_i;
            r_rd      <= rd_i;
            r_acc     <= {32'd0, funct3_i[2] ? w_a_mag : w_b_mag};
            r_opnd    <= funct3_i[2] ? w_b_mag : w_a_mag;
            r_neg_lo  <= (w_a_sgn & rs1_data_i[31]) ^ (w_b_sgn & rs2_data_i[31]);
            r_neg_rem <= w_a_sgn & rs1_data_i[31];
            r_cnt     <= 5'd0;
            if (!funct3_i[2]) begin
              r_state <= S_MUL;
            end else if (w_fast) begin
              r_state  <= S_DONE;
              result_o <= w_fast_res;
              rd_o     <= rd_i;
            end else begin
              r_state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == C_LAST_ITER) begin
            r_state  <= S_DONE;
            result_o <= w_mul_res;
            rd_o     <= r_rd;
          end
        end
        S_DIV: begin
          r_acc <= w_div_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == C_LAST_ITER) begin
            r_state  <= S_DONE;
            result_o <= w_div_res;
            rd_o     <= r_rd;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from the state register; the stall also covers the
  // accepting cycle so the instruction stays in ID/EX until the result is back.
  assign busy_o  = (r_state == S_MUL) || (r_state == S_DIV);
  assign done_o  = (r_state == S_DONE);
  assign stall_o = ((r_state == S_IDLE) && w_req && !flush_i) || busy_o;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Directed self-checking bench for ex_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [6:0]  op_i;
  logic [6:0]  funct7_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int nvec = 0;
  int nerr = 0;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  ex_muldiv dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .op_i       (op_i),
    .funct7_i   (funct7_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_i       (rd_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_o       (rd_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
    op_i       = 7'b0110011;
    funct7_i   = 7'b0000001;
    funct3_i   = f3;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_i       = rd;
  endtask

  task automatic drop_req();
    op_i     = 7'b0000000;
    funct7_i = 7'b0000000;
  endtask

  // Issues one request in the current cycle (C) and observes until done_o.
  // lat is the cycle offset of done_o after C (-1 when it never came).
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       output int lat, output int stalls, output int busys,
                       output logic [31:0] res, output logic [4:0] rdo);
    lat = -1; stalls = 0; busys = 0; res = 'x; rdo = 'x;
    drive_req(f3, a, b, rd);
    #1;
    if (stall_o) stalls++;
    step();
    drop_req();
    for (int k = 1; k <= 40; k++) begin
      if (done_o) begin
        lat = k; res = result_o; rdo = rd_o;
        if (stall_o) stalls++;
        step();
        break;
      end
      if (stall_o) stalls++;
      if (busy_o) busys++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; funct3_i = 3'd0;
    rs1_data_i = 32'd0; rs2_data_i = 32'd0; rd_i = 5'd0;
    drop_req();
    step(); step();
    nvec++; if (result_o !== 32'd0) begin nerr++; $display("FAIL reset_result: got %h expected %h", result_o, 32'd0); end
    nvec++; if (rd_o !== 5'd0) begin nerr++; $display("FAIL reset_rd: got %0d expected 0", rd_o); end
    nvec++; if (done_o !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b expected 0", done_o); end
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_mul_timing();
    int lat, st, bz; logic [31:0] r; logic [4:0] d;
    do_op(F_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, lat, st, bz, r, d);
    nvec++; if (r !== 32'hFFFFFFEB) begin nerr++; $display("FAIL mul_result: got %h expected %h", r, 32'hFFFFFFEB); end
    nvec++; if (d !== 5'd5) begin nerr++; $display("FAIL mul_rd: got %0d expected 5", d); end
    nvec++; if (lat != 33) begin nerr++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    nvec++; if (st != 33) begin nerr++; $display("FAIL mul_stall_cycles: got %0d expected 33", st); end
    nvec++; if (bz != 32) begin nerr++; $display("FAIL mul_busy_cycles: got %0d expected 32", bz); end
    nvec++; if (done_o !== 1'b0) begin nerr++; $display("FAIL mul_done_pulse: got %b expected 0", done_o); end
    nvec++; if (result_o !== 32'hFFFFFFEB) begin nerr++; $display("FAIL mul_hold: got %h expected %h", result_o, 32'hFFFFFFEB); end
  endtask

  task automatic test_mul_high();
    int lat, st, bz; logic [31:0] r; logic [4:0] d;
    do_op(F_MULH, 32'h80000000, 32'h80000000, 5'd6, lat, st, bz, r, d);
    nvec++; if (r !== 32'h40000000) begin nerr++; $display("FAIL mulh: got %h expected %h", r, 32'h40000000); end
    do_op(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, lat, st, bz, r, d);
    nvec++; if (r !== 32'hFFFFFFFE) begin nerr++; $display("FAIL mulhu: got %h expected %h", r, 32'hFFFFFFFE); end
    nvec++; if (d !== 5'd7) begin nerr++; $display("FAIL mulhu_rd: got %0d expected 7", d); end
    do_op(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, lat, st, bz, r, d);
    nvec++; if (r !== 32'hFFFFFFFF) begin nerr++; $display("FAIL mulhsu: got %h expected %h", r, 32'hFFFFFFFF); end
    nvec++; if (lat != 33) begin nerr++; $display("FAIL mulhsu_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_divide();
    int lat, st, bz; logic [31:0] r; logic [4:0] d;
    do_op(F_DIV, 32'hFFFFFFF9, 32'd2, 5'd10, lat, st, bz, r, d);
    nvec++; if (r !== 32'hFFFFFFFD) begin nerr++; $display("FAIL div_neg: got %h expected %h", r, 32'hFFFFFFFD); end
    nvec++; if (lat != 33) begin nerr++; $display("FAIL div_latency: got %0d expected 33", lat); end
    do_op(F_REM, 32'hFFFFFFF9, 32'd2, 5'd11, lat, st, bz, r, d);
    nvec++; if (r !== 32'hFFFFFFFF) begin nerr++; $display("FAIL rem_neg: got %h expected %h", r, 32'hFFFFFFFF); end
    do_op(F_DIVU, 32'd7, 32'd2, 5'd12, lat, st, bz, r, d);
    nvec++; if (r !== 32'd3) begin nerr++; $display("FAIL divu: got %h expected %h", r, 32'd3); end
    do_op(F_REMU, 32'd7, 32'd2, 5'd13, lat, st, bz, r, d);
    nvec++; if (r !== 32'd1) begin nerr++; $display("FAIL remu: got %h expected %h", r, 32'd1); end
    do_op(F_DIVU, 32'hFFFFFFFF, 32'd3, 5'd14, lat, st, bz, r, d);
    nvec++; if (r !== 32'h55555555) begin nerr++; $display("FAIL divu_big: got %h expected %h", r, 32'h55555555); end
    do_op(F_REMU, 32'hFFFFFFFF, 32'd10, 5'd15, lat, st, bz, r, d);
    nvec++; if (r !== 32'd5) begin nerr++; $display("FAIL remu_big: got %h expected %h", r, 32'd5); end
  endtask

  task automatic test_fast_path();
    int lat, st, bz; logic [31:0] r; logic [4:0] d;
    do_op(F_DIV, 32'd5, 32'd0, 5'd1, lat, st, bz, r, d);
    nvec++; if (r !== 32'hFFFFFFFF) begin nerr++; $display("FAIL div_by_zero: got %h expected %h", r, 32'hFFFFFFFF); end
    nvec++; if (lat != 1) begin nerr++; $display("FAIL div_by_zero_latency: got %0d expected 1", lat); end
    nvec++; if (st != 1) begin nerr++; $display("FAIL div_by_zero_stall: got %0d expected 1", st); end
    do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd2, lat, st, bz, r, d);
    nvec++; if (r !== 32'h80000000) begin nerr++; $display("FAIL div_ovf: got %h expected %h", r, 32'h80000000); end
    nvec++; if (lat != 1) begin nerr++; $display("FAIL div_ovf_latency: got %0d expected 1", lat); end
    nvec++; if (bz != 0) begin nerr++; $display("FAIL div_ovf_busy: got %0d expected 0", bz); end
    do_op(F_REM, 32'h80000000, 32'hFFFFFFFF, 5'd3, lat, st, bz, r, d);
    nvec++; if (r !== 32'd0) begin nerr++; $display("FAIL rem_ovf: got %h expected %h", r, 32'd0); end
    do_op(F_REMU, 32'd5, 32'd0, 5'd4, lat, st, bz, r, d);
    nvec++; if (r !== 32'd5) begin nerr++; $display("FAIL remu_by_zero: got %h expected %h", r, 32'd5); end
    nvec++; if (d !== 5'd4) begin nerr++; $display("FAIL remu_by_zero_rd: got %0d expected 4", d); end
    nvec++; if (lat != 1) begin nerr++; $display("FAIL remu_by_zero_latency: got %0d expected 1", lat); end
  endtask

  // Expects the previous completion to be REMU 5/0 -> 5 into rd 4.
  task automatic test_flush_back_to_back();
    int lat, st, bz; logic [31:0] r; logic [4:0] d;
    drive_req(F_DIVU, 32'd100, 32'd7, 5'd3);
    flush_i = 1'b1;
    #1;
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL flush_idle_stall: got %b expected 0", stall_o); end
    step();
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL flush_idle_accept: got %b expected 0", busy_o); end
    flush_i = 1'b0;
    step();
    drop_req();
    repeat (9) step();
    nvec++; if (busy_o !== 1'b1) begin nerr++; $display("FAIL flush_pre_busy: got %b expected 1", busy_o); end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL flush_busy: got %b expected 0", busy_o); end
    nvec++; if (done_o !== 1'b0) begin nerr++; $display("FAIL flush_done: got %b expected 0", done_o); end
    nvec++; if (result_o !== 32'd5) begin nerr++; $display("FAIL flush_result_hold: got %h expected %h", result_o, 32'd5); end
    nvec++; if (rd_o !== 5'd4) begin nerr++; $display("FAIL flush_rd_hold: got %0d expected 4", rd_o); end
    do_op(F_MUL, 32'd6, 32'd7, 5'd12, lat, st, bz, r, d);
    nvec++; if (r !== 32'd42) begin nerr++; $display("FAIL b2b_mul: got %h expected %h", r, 32'd42); end
    nvec++; if (d !== 5'd12) begin nerr++; $display("FAIL b2b_mul_rd: got %0d expected 12", d); end
    nvec++; if (lat != 33) begin nerr++; $display("FAIL b2b_mul_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_reset_mid_op();
    int lat, st, bz; logic [31:0] r; logic [4:0] d;
    drive_req(F_MUL, 32'd5, 32'd5, 5'd7);
    step();
    drop_req();
    repeat (10) step();
    rst_i = 1'b1;
    #1;
    nvec++; if (result_o !== 32'd0) begin nerr++; $display("FAIL midrst_result: got %h expected %h", result_o, 32'd0); end
    nvec++; if (rd_o !== 5'd0) begin nerr++; $display("FAIL midrst_rd: got %0d expected 0", rd_o); end
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL midrst_stall: got %b expected 0", stall_o); end
    nvec++; if (done_o !== 1'b0) begin nerr++; $display("FAIL midrst_done: got %b expected 0", done_o); end
    step();
    rst_i = 1'b0;
    step();
    do_op(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, lat, st, bz, r, d);
    nvec++; if (r !== 32'hFFFFFFFE) begin nerr++; $display("FAIL post_reset_op: got %h expected %h", r, 32'hFFFFFFFE); end
    nvec++; if (lat != 33) begin nerr++; $display("FAIL post_reset_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_done_hold();
    drive_req(F_MUL, 32'd3, 32'd4, 5'd9);
    #1;
    nvec++; if (stall_o !== 1'b1) begin nerr++; $display("FAIL hold_accept_stall: got %b expected 1", stall_o); end
    repeat (33) step();
    nvec++; if (done_o !== 1'b1) begin nerr++; $display("FAIL hold_done: got %b expected 1", done_o); end
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL hold_done_stall: got %b expected 0", stall_o); end
    nvec++; if (result_o !== 32'd12) begin nerr++; $display("FAIL hold_result: got %h expected %h", result_o, 32'd12); end
    step();
    nvec++; if (done_o !== 1'b0) begin nerr++; $display("FAIL hold_idle_done: got %b expected 0", done_o); end
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL hold_idle_busy: got %b expected 0", busy_o); end
    nvec++; if (stall_o !== 1'b1) begin nerr++; $display("FAIL hold_idle_stall: got %b expected 1", stall_o); end
    step();
    nvec++; if (busy_o !== 1'b1) begin nerr++; $display("FAIL hold_reaccept: got %b expected 1", busy_o); end
    drop_req();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL hold_flush_busy: got %b expected 0", busy_o); end
    step();
    nvec++; if (done_o !== 1'b0) begin nerr++; $display("FAIL hold_flush_done: got %b expected 0", done_o); end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_high();
    test_divide();
    test_fast_path();
    test_flush_back_to_back();
    test_reset_mid_op();
    test_done_hold();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
